tone_scheduler: RTL

TONE_SCHEDULER -- requirements
Module: tone_scheduler

---
 rtl/tone_scheduler_if.sv | 26 ++
 rtl/tone_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tone_scheduler_if.sv
// Request/tone bundle between the voice requesters (master) and the tone scheduler (slave).
interface tone_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DIV_BW  = 16,
  parameter int DUR_BW  = 8
);
  logic                       strb_i;
  logic [NUM_REQ-1:0]         req_i;
  logic [NUM_REQ*DIV_BW-1:0]  div_i;
  logic [NUM_REQ*DUR_BW-1:0]  dur_i;
  logic [NUM_REQ-1:0]         grant_o;
  logic [NUM_REQ-1:0]         done_o;
  logic [DIV_BW-1:0]          period_o;
  logic [DIV_BW-1:0]          duty_o;
  logic                       busy_o;

  modport master (
    output strb_i, req_i, div_i, dur_i,
    input  grant_o, done_o, period_o, duty_o, busy_o
  );

  modport slave (
    input  strb_i, req_i, div_i, dur_i,
    output grant_o, done_o, period_o, duty_o, busy_o
  );
endinterface

// File: rtl/tone_scheduler.sv
// Round-robin owner of a single PWM tone path: each winner plays max(dur,1) strobe beats,
// framed by one LOAD cycle before and one GAP cycle after; all outputs registered.
module tone_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DIV_BW  = 16,
  parameter int DUR_BW  = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  tone_scheduler_if.slave bus
);
  localparam int PTR_BW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t              r_state, w_state_nxt;
  logic [PTR_BW-1:0]   r_ptr, w_ptr_nxt;
  logic [PTR_BW-1:0]   r_win, w_win_nxt;
  logic [DIV_BW-1:0]   r_div, w_div_nxt;
  logic [DUR_BW-1:0]   r_rem, w_rem_nxt;
  logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]  r_done, w_done_nxt;
  logic [DIV_BW-1:0]   r_period, w_period_nxt;
  logic [DIV_BW-1:0]   r_duty, w_duty_nxt;
  logic                r_busy, w_busy_nxt;

  logic [DIV_BW-1:0]   w_div_arr [NUM_REQ];
  logic [DUR_BW-1:0]   w_dur_arr [NUM_REQ];
  logic [DUR_BW-1:0]   w_dur_sel;
  logic [PTR_BW-1:0]   w_rr;
  logic                w_any;
  logic                w_owner_req;
  int                  w_idx;

  always_comb begin
    for (int n = 0; n < NUM_REQ; n++) begin
      w_div_arr[n] = bus.div_i[n*DIV_BW +: DIV_BW];
      w_dur_arr[n] = bus.dur_i[n*DUR_BW +: DUR_BW];
    end
  end

  // Scan from the farthest candidate back to the nearest so the index right after r_ptr wins.
  always_comb begin
    w_rr  = r_ptr;
    w_idx = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (bus.req_i[PTR_BW'(w_idx)]) w_rr = PTR_BW'(w_idx);
    end
  end

  assign w_any       = |bus.req_i;
  assign w_owner_req = bus.req_i[r_win];
  assign w_dur_sel   = w_dur_arr[w_rr];

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_win_nxt    = r_win;
    w_div_nxt    = r_div;
    w_rem_nxt    = r_rem;
    w_grant_nxt  = r_grant;
    w_done_nxt   = '0;
    w_period_nxt = r_period;
    w_duty_nxt   = r_duty;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = LOAD;
          w_win_nxt   = w_rr;
          w_ptr_nxt   = w_rr;
          w_grant_nxt = NUM_REQ'(1) << w_rr;
          w_div_nxt   = w_div_arr[w_rr];
          w_rem_nxt   = (w_dur_sel == '0) ? DUR_BW'(1) : w_dur_sel;
        end
      end
      LOAD: begin
        if (!w_owner_req) begin
          w_state_nxt = GAP;
          w_grant_nxt = '0;
        end else begin
          w_state_nxt  = PLAY;
          w_period_nxt = r_div;
          w_duty_nxt   = r_div >> 1;
        end
      end
      PLAY: begin
        // A dropped request beats a coinciding final strobe: no done pulse on abort.
        if (!w_owner_req) begin
          w_state_nxt  = GAP;
          w_grant_nxt  = '0;
          w_period_nxt = '0;
          w_duty_nxt   = '0;
        end else if (bus.strb_i) begin
          if (r_rem == DUR_BW'(1)) begin
            w_state_nxt  = GAP;
            w_done_nxt   = r_grant;
            w_grant_nxt  = '0;
            w_period_nxt = '0;
            w_duty_nxt   = '0;
          end else begin
            w_rem_nxt = r_rem - DUR_BW'(1);
          end
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_ptr    <= PTR_BW'(NUM_REQ - 1);
      r_win    <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_period <= '0;
      r_duty   <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_win    <= w_win_nxt;
      r_div    <= w_div_nxt;
      r_rem    <= w_rem_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_period <= w_period_nxt;
      r_duty   <= w_duty_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.grant_o  = r_grant;
  assign bus.done_o   = r_done;
  assign bus.period_o = r_period;
  assign bus.duty_o   = r_duty;
  assign bus.busy_o   = r_busy;
endmodule
